vga_scaled_display: RTL

VGA_SCALED_DISPLAY -- requirements
Module: vga_scaled_display

---
 rtl/vga_scaled_display_if.sv | 33 +++
 rtl/vga_scaled_display.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_scaled_display_if.sv
// Framebuffer read port and video output bundle of vga_scaled_display.
//   master (display engine): drives pixel_addr and the video outputs,
//                            receives pixel_data.
//   slave  (framebuffer / monitor side): the mirror image.
// There is no valid/ready handshake on this bus. pixel_addr is issued
// every clock. pixel_data must return the word for an address exactly
// RAM_LATENCY clocks after that address was presented. Every video output
// (hsync, vsync, red/green/blue, video_on, frame_start) describes the same
// pixel in the same clock.
interface vga_scaled_display_if #(
  parameter int ADDR_W  = 17,
  parameter int COLOR_W = 4
);
  logic [3*COLOR_W-1:0] pixel_data;
  logic [ADDR_W-1:0]    pixel_addr;
  logic                 hsync;
  logic                 vsync;
  logic [COLOR_W-1:0]   red;
  logic [COLOR_W-1:0]   green;
  logic [COLOR_W-1:0]   blue;
  logic                 video_on;
  logic                 frame_start;

  modport master (
    input  pixel_data,
    output pixel_addr, hsync, vsync, red, green, blue, video_on, frame_start
  );

  modport slave (
    output pixel_data,
    input  pixel_addr, hsync, vsync, red, green, blue, video_on, frame_start
  );
endinterface

// File: rtl/vga_scaled_display.sv
// VGA timing generator that scans a framebuffer of size
// (H_DISPLAY >> SCALE_SHIFT) x (V_DISPLAY >> SCALE_SHIFT). Each framebuffer
// pixel is shown as a 2^SCALE_SHIFT x 2^SCALE_SHIFT block on screen.
// Ports:
//   clk       - pixel clock
//   reset     - asynchronous, active-high
//   test_mode - (only with VGA_TEST_PATTERN_EN) 1 selects eight vertical
//               colour bars instead of pixel_data
//   vga       - vga_scaled_display_if.master. It carries pixel_addr out and
//               pixel_data in, plus hsync/vsync/RGB/video_on/frame_start out.
// Optional feature macro: VGA_TEST_PATTERN_EN.
// Latency: counter value -> pixel_addr takes 1 clock.
//          counter value -> every video output takes RAM_LATENCY+2 clocks.
module vga_scaled_display #(
  parameter int H_DISPLAY   = 1920,
  parameter int H_FP        = 88,
  parameter int H_SYNC      = 44,
  parameter int H_BP        = 148,
  parameter int V_DISPLAY   = 1080,
  parameter int V_FP        = 4,
  parameter int V_SYNC      = 5,
  parameter int V_BP        = 36,
  parameter int HSYNC_POL   = 0,
  parameter int VSYNC_POL   = 0,
  parameter int SCALE_SHIFT = 3,
  parameter int RAM_LATENCY = 1,
  parameter int ADDR_W      = 17,
  parameter int COLOR_W     = 4
) (
  input  logic clk,
  input  logic reset,
`ifdef VGA_TEST_PATTERN_EN
  input  logic test_mode,
`endif
  vga_scaled_display_if.master vga
);
  localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int FB_W    = H_DISPLAY >> SCALE_SHIFT;
  localparam int DLY     = RAM_LATENCY + 2;
  localparam int DW      = 3 * COLOR_W;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_DISPLAY);
  localparam logic [HW-1:0] HS_BEG = HW'(H_DISPLAY + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_DISPLAY + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_SUB  = HW'((1 << SCALE_SHIFT) - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_DISPLAY);
  localparam logic [VW-1:0] VS_BEG = VW'(V_DISPLAY + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_DISPLAY + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_SUB  = VW'((1 << SCALE_SHIFT) - 1);
  localparam logic [ADDR_W-1:0] FB_W_A = ADDR_W'(FB_W);
  localparam logic HS_ON = 1'(HSYNC_POL);
  localparam logic VS_ON = 1'(VSYNC_POL);

  if ((H_DISPLAY % (1 << SCALE_SHIFT)) != 0 || (V_DISPLAY % (1 << SCALE_SHIFT)) != 0) begin : g_bad_scale
    $error("H_DISPLAY and V_DISPLAY must be multiples of 2**SCALE_SHIFT");
  end
  if (RAM_LATENCY < 1 || RAM_LATENCY > 4) begin : g_bad_lat
    $error("RAM_LATENCY must be in 1..4");
  end

  // Control bits that travel alongside the pixel through the delay line.
  typedef struct packed {
    logic hs;
    logic vs;
    logic vid;
    logic fs;
  } ctl_t;
  localparam ctl_t CTL_RST = '{hs: ~HS_ON, vs: ~VS_ON, vid: 1'b0, fs: 1'b0};

  logic [HW-1:0]     h_q, h_d;
  logic [VW-1:0]     v_q, v_d, v_nxt;
  logic [ADDR_W-1:0] col_q, col_d, row_base_q, row_base_d;
  logic [ADDR_W-1:0] pixel_addr_q, pixel_addr_d;
  logic [DW-1:0]     rgb_q, rgb_d;
  logic              line_end, h_act, v_act;
  ctl_t              ctl_raw;
  ctl_t              ctl_q [DLY];

  assign line_end = (h_q == H_LAST);
  assign h_act    = (h_q < H_ACT);
  assign v_act    = (v_q < V_ACT);
  assign v_nxt    = v_q + 1'b1;

  // The address is row_base + column; both are accumulators, so no
  // multiplier is needed. The column steps after the last screen pixel of
  // each scaled block. Row_base steps by FB_W when the next line starts a
  // new block row inside the active area.
  always_comb begin
    h_d        = h_q + 1'b1;
    v_d        = v_q;
    col_d      = col_q;
    row_base_d = row_base_q;
    if (line_end) begin
      h_d   = '0;
      col_d = '0;
      if (v_q == V_LAST) begin
        v_d        = '0;
        row_base_d = '0;
      end else begin
        v_d = v_nxt;
        if (((v_nxt & V_SUB) == '0) && (v_nxt < V_ACT)) begin
          row_base_d = row_base_q + FB_W_A;
        end
      end
    end else if (h_act && ((h_q & H_SUB) == H_SUB)) begin
      col_d = col_q + 1'b1;
    end
  end

  always_comb begin
    pixel_addr_d = (h_act && v_act) ? (row_base_q + col_q) : '0;
    ctl_raw.hs   = (h_q >= HS_BEG && h_q < HS_END) ? HS_ON : ~HS_ON;
    ctl_raw.vs   = (v_q >= VS_BEG && v_q < VS_END) ? VS_ON : ~VS_ON;
    ctl_raw.vid  = h_act && v_act;
    ctl_raw.fs   = (h_q == '0) && (v_q == '0);
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_DISPLAY / 8;
  localparam logic [HW-1:0] BAR_LAST = HW'(BAR_W - 1);
  if ((H_DISPLAY % 8) != 0) begin : g_bad_bar
    $error("H_DISPLAY must be a multiple of 8 for the test pattern");
  end

  logic [2:0]    bar_q, bar_d, bar_sel;
  logic [HW-1:0] bar_pos_q, bar_pos_d;
  // The bar index is taken alongside the counter and then delayed.
  // This puts it at the RGB register in the same clock as its pixel_data.
  logic [2:0]    bar_pipe_q [DLY-1];

  always_comb begin
    bar_d     = bar_q;
    bar_pos_d = bar_pos_q;
    if (line_end) begin
      bar_d     = '0;
      bar_pos_d = '0;
    end else if (h_act) begin
      if (bar_pos_q == BAR_LAST) begin
        bar_pos_d = '0;
        bar_d     = bar_q + 1'b1;
      end else begin
        bar_pos_d = bar_pos_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bar_q     <= '0;
      bar_pos_q <= '0;
      for (int i = 0; i < DLY - 1; i++) bar_pipe_q[i] <= '0;
    end else begin
      bar_q         <= bar_d;
      bar_pos_q     <= bar_pos_d;
      bar_pipe_q[0] <= bar_q;
      for (int i = 1; i < DLY - 1; i++) bar_pipe_q[i] <= bar_pipe_q[i-1];
    end
  end

  assign bar_sel = bar_pipe_q[DLY-2];
`endif

  // RGB is captured in the same clock that the final control stage is
  // loaded. For that reason it tests video_on one stage earlier.
  always_comb begin
    rgb_d = '0;
    if (ctl_q[DLY-2].vid) begin
`ifdef VGA_TEST_PATTERN_EN
      if (test_mode) begin
        rgb_d = {{COLOR_W{bar_sel[2]}}, {COLOR_W{bar_sel[1]}}, {COLOR_W{bar_sel[0]}}};
      end else begin
        rgb_d = vga.pixel_data;
      end
`else
      rgb_d = vga.pixel_data;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q          <= '0;
      v_q          <= '0;
      col_q        <= '0;
      row_base_q   <= '0;
      pixel_addr_q <= '0;
      rgb_q        <= '0;
      for (int i = 0; i < DLY; i++) ctl_q[i] <= CTL_RST;
    end else begin
      h_q          <= h_d;
      v_q          <= v_d;
      col_q        <= col_d;
      row_base_q   <= row_base_d;
      pixel_addr_q <= pixel_addr_d;
      rgb_q        <= rgb_d;
      ctl_q[0]     <= ctl_raw;
      for (int i = 1; i < DLY; i++) ctl_q[i] <= ctl_q[i-1];
    end
  end

  assign vga.pixel_addr  = pixel_addr_q;
  assign vga.hsync       = ctl_q[DLY-1].hs;
  assign vga.vsync       = ctl_q[DLY-1].vs;
  assign vga.video_on    = ctl_q[DLY-1].vid;
  assign vga.frame_start = ctl_q[DLY-1].fs;
  assign vga.red         = rgb_q[DW-1:2*COLOR_W];
  assign vga.green       = rgb_q[2*COLOR_W-1:COLOR_W];
  assign vga.blue        = rgb_q[COLOR_W-1:0];
endmodule
